riscv_irq_arbiter: RTL and testbench

Parametrised machine-level external interrupt controller that sits in front of the core's trap/CSR block. It gathers NUM_SRC level- or edge-triggered sources and holds per-source pending and in-flight state. It arbitrates by programmable priority against a threshold and drives a single meip-style request plus the winning ID. Software services a request through a claim/complete handshake on a small register port.

---
 rtl/riscv_irq_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_riscv_irq_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_irq_arbiter
// Brief    : Machine-level external interrupt controller. Level/edge gateways
//            with pending, in-flight and deferred state, priority arbitration
//            against a threshold, and a claim/complete register port.
//            Define RISCV_IRQ_SYNC_EN to add 2-flop synchronisers on src_irq.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_irq_arbiter #(
    parameter int                 NUM_SRC   = 8,
    parameter int                 PRIO_W    = 3,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic [7:0]         reg_addr,
    input  logic               reg_we,
    input  logic               reg_re,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               irq_out,
    output logic [4:0]         irq_id
);

    localparam logic [7:0] C_ADDR_ENABLE  = 8'h20;
    localparam logic [7:0] C_ADDR_THRESH  = 8'h21;
    localparam logic [7:0] C_ADDR_PENDING = 8'h22;
    localparam logic [7:0] C_ADDR_CLAIM   = 8'h23;

    logic [NUM_SRC-1:0] w_src;
    logic [NUM_SRC-1:0] w_rise;
    logic               w_claim;
    logic               w_complete;
    logic               w_unused_wdata;

    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [NUM_SRC-1:0] enable_q;
    logic [PRIO_W-1:0]  threshold_q;
    logic [NUM_SRC-1:0] pending_q,  pending_d;
    logic [NUM_SRC-1:0] inflight_q, inflight_d;
    logic [NUM_SRC-1:0] deferred_q, deferred_d;
    logic [NUM_SRC-1:0] src_prev_q;
    logic [4:0]         irq_id_q,   irq_id_d;
    logic               irq_out_q;
    logic [PRIO_W-1:0]  w_best_prio;

`ifdef RISCV_IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q;
    logic [NUM_SRC-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_irq;
            sync2_q <= sync1_q;
        end
    end

    assign w_src = sync2_q;
`else
    assign w_src = src_irq;
`endif

    assign w_rise         = EDGE_MASK & w_src & ~src_prev_q;
    assign w_claim        = reg_re && (reg_addr == C_ADDR_CLAIM);
    assign w_complete     = reg_we && (reg_addr == C_ADDR_CLAIM);
    assign w_unused_wdata = ^reg_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                prio_q[i] <= '0;
            end
            enable_q    <= '0;
            threshold_q <= '0;
        end else if (reg_we) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (reg_addr == 8'(i + 1)) begin
                    prio_q[i] <= reg_wdata[PRIO_W-1:0];
                end
            end
            if (reg_addr == C_ADDR_ENABLE) begin
                enable_q <= reg_wdata[NUM_SRC:1];
            end
            if (reg_addr == C_ADDR_THRESH) begin
                threshold_q <= reg_wdata[PRIO_W-1:0];
            end
        end
    end

    // Gateway first, then claim overrides it, then complete releases deferred edges.
    always_comb begin
        pending_d  = pending_q;
        inflight_d = inflight_q;
        deferred_d = deferred_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (EDGE_MASK[i]) begin
                if (w_rise[i]) begin
                    if (inflight_q[i]) begin
                        deferred_d[i] = 1'b1;
                    end else begin
                        pending_d[i] = 1'b1;
                    end
                end
            end else if (w_src[i] && !inflight_q[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
            end

            if (w_claim && (irq_id_q == 5'(i + 1))) begin
                pending_d[i]  = 1'b0;
                inflight_d[i] = 1'b1;
                if (w_rise[i]) begin
                    deferred_d[i] = 1'b1;
                end
            end

            if (w_complete && (reg_wdata[4:0] == 5'(i + 1)) && inflight_q[i]) begin
                inflight_d[i] = 1'b0;
                if (EDGE_MASK[i] && deferred_d[i]) begin
                    deferred_d[i] = 1'b0;
                    pending_d[i]  = 1'b1;
                end
            end
        end
    end

    // Ascending scan with strict '>' keeps the lowest ID on priority ties.
    always_comb begin
        w_best_prio = threshold_q;
        irq_id_d    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending_q[i] && enable_q[i] && (prio_q[i] > w_best_prio)) begin
                w_best_prio = prio_q[i];
                irq_id_d    = 5'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            inflight_q <= '0;
            deferred_q <= '0;
            src_prev_q <= '0;
            irq_id_q   <= '0;
            irq_out_q  <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            deferred_q <= deferred_d;
            src_prev_q <= w_src;
            irq_id_q   <= irq_id_d;
            irq_out_q  <= (irq_id_d != 5'd0);
        end
    end

    always_comb begin
        reg_rdata = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (reg_addr == 8'(i + 1)) begin
                reg_rdata = 32'(prio_q[i]);
            end
        end
        case (reg_addr)
            C_ADDR_ENABLE:  reg_rdata = 32'({enable_q, 1'b0});
            C_ADDR_THRESH:  reg_rdata = 32'(threshold_q);
            C_ADDR_PENDING: reg_rdata = 32'({pending_q, 1'b0});
            C_ADDR_CLAIM:   reg_rdata = 32'(irq_id_q);
            default:        ;
        endcase
    end

    assign irq_out = irq_out_q;
    assign irq_id  = irq_id_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_irq_arbiter
// Brief    : Directed and random checks of riscv_irq_arbiter against a
//            behavioural model of the gateway/claim/complete rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_irq_arbiter;

    localparam int             NUM  = 8;
    localparam int             PW   = 3;
    localparam logic [NUM-1:0] EDGE = 8'h09;
`ifdef RISCV_IRQ_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic [NUM-1:0] src_irq   = '0;
    logic [7:0]     reg_addr  = '0;
    logic           reg_we    = 1'b0;
    logic           reg_re    = 1'b0;
    logic [31:0]    reg_wdata = '0;
    logic [31:0]    reg_rdata;
    logic           irq_out;
    logic [4:0]     irq_id;

    int n_checks = 0;
    int n_fail   = 0;

    int m_prio [0:NUM];
    bit m_en   [0:NUM];
    bit m_pend [0:NUM];
    bit m_infl [0:NUM];
    bit m_def  [0:NUM];
    bit m_prev [0:NUM];
    bit m_s1   [0:NUM];
    bit m_s2   [0:NUM];
    int m_thr;
    int m_irq_id;
    bit m_irq_out;

    riscv_irq_arbiter #(
        .NUM_SRC   (NUM),
        .PRIO_W    (PW),
        .EDGE_MASK (EDGE)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .src_irq   (src_irq),
        .reg_addr  (reg_addr),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .irq_out   (irq_out),
        .irq_id    (irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= NUM; i++) begin
            m_prio[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_infl[i] = 0;
            m_def[i]  = 0; m_prev[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
        end
        m_thr = 0; m_irq_id = 0; m_irq_out = 0;
    endtask

    function automatic logic [31:0] m_rdata(input logic [7:0] a);
        logic [31:0] r;
        r = '0;
        if (a >= 8'd1 && a <= 8'(NUM)) r = 32'(m_prio[int'(a)]);
        else if (a == 8'h20) for (int i = 1; i <= NUM; i++) r[i] = m_en[i];
        else if (a == 8'h21) r = 32'(m_thr);
        else if (a == 8'h22) for (int i = 1; i <= NUM; i++) r[i] = m_pend[i];
        else if (a == 8'h23) r = 32'(m_irq_id);
        return r;
    endfunction

    // One clock: predict from pre-edge state and inputs, then compare outputs.
    task automatic tick();
        int best, win, cid, pid;
        bit line [0:NUM];
        bit rise [0:NUM];
        bit np [0:NUM];
        bit ni [0:NUM];
        bit nd [0:NUM];
        if (rst) begin
            @(posedge clk); #1;
            model_reset();
        end else begin
            best = -1;
            for (int i = 1; i <= NUM; i++)
                if (m_pend[i] && m_en[i] && m_prio[i] > m_thr && m_prio[i] > best) best = m_prio[i];
            win = 0;
            for (int i = NUM; i >= 1; i--)
                if (m_pend[i] && m_en[i] && m_prio[i] > m_thr && m_prio[i] == best) win = i;
            cid = (reg_re && reg_addr == 8'h23) ? m_irq_id : 0;
            pid = (reg_we && reg_addr == 8'h23) ? int'(reg_wdata[4:0]) : 0;
            for (int i = 1; i <= NUM; i++) begin
                line[i] = (SD == 0) ? src_irq[i-1] : m_s2[i];
                rise[i] = EDGE[i-1] && line[i] && !m_prev[i];
                np[i] = m_pend[i]; ni[i] = m_infl[i]; nd[i] = m_def[i];
                if (EDGE[i-1]) begin
                    if (rise[i]) begin
                        if (m_infl[i]) nd[i] = 1; else np[i] = 1;
                    end
                end else if (line[i] && !m_infl[i] && !m_pend[i]) begin
                    np[i] = 1;
                end
                if (cid == i) begin
                    np[i] = 0; ni[i] = 1;
                    if (rise[i]) nd[i] = 1;
                end
                if (pid == i && m_infl[i]) begin
                    ni[i] = 0;
                    if (EDGE[i-1] && nd[i]) begin nd[i] = 0; np[i] = 1; end
                end
            end
            @(posedge clk); #1;
            if (reg_we) begin
                if (reg_addr >= 8'd1 && reg_addr <= 8'(NUM)) m_prio[int'(reg_addr)] = int'(reg_wdata[PW-1:0]);
                else if (reg_addr == 8'h20) for (int i = 1; i <= NUM; i++) m_en[i] = reg_wdata[i];
                else if (reg_addr == 8'h21) m_thr = int'(reg_wdata[PW-1:0]);
            end
            for (int i = 1; i <= NUM; i++) begin
                m_pend[i] = np[i]; m_infl[i] = ni[i]; m_def[i] = nd[i];
                m_prev[i] = line[i]; m_s2[i] = m_s1[i]; m_s1[i] = src_irq[i-1];
            end
            m_irq_id  = win;
            m_irq_out = (win != 0);
        end
        chk("irq_out", 32'(irq_out), 32'(m_irq_out));
        chk("irq_id",  32'(irq_id),  32'(m_irq_id));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_addr = a; reg_wdata = d; reg_we = 1'b1;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        reg_addr = a; #1;
        chk(tag, reg_rdata, exp);
    endtask

    task automatic claim(input string tag, input logic [31:0] exp);
        reg_addr = 8'h23; reg_re = 1'b1; #1;
        chk(tag, reg_rdata, exp);
        tick();
        reg_re = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    logic [7:0] addr_tab [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                  8'h07, 8'h08, 8'h20, 8'h21, 8'h22, 8'h30};

    initial begin
        int n;
        logic [7:0] a;
        model_reset();

        // Reset state
        ticks(2);
        chk("rst_irq_out", 32'(irq_out), 32'h0);
        chk("rst_irq_id", 32'(irq_id), 32'h0);
        rst = 1'b0;
        rd("rst_rdata_0", 8'h00, 32'h0);
        rd("rst_pending", 8'h22, 32'h0);
        rd("rst_enable", 8'h20, 32'h0);

        // Level source 3
        wr(8'h03, 32'd2); wr(8'h21, 32'd0); wr(8'h20, 32'h08);
        src_irq[2] = 1'b1;
        n = 0;
        while (!irq_out && n < 10) begin tick(); n++; end
        chk("lvl_latency", 32'(n), 32'(2 + SD));
        chk("lvl_id", 32'(irq_id), 32'd3);
        claim("lvl_claim", 32'd3);
        rd("lvl_pend_cleared", 8'h22, 32'h00);
        tick();
        chk("lvl_irq_drop", 32'(irq_out), 32'h0);
        wr(8'h23, 32'd3);
        ticks(3);
        rd("lvl_repend", 8'h22, 32'h08);
        chk("lvl_irq_again", 32'(irq_out), 32'h1);

        // Priority and ties
        src_irq = '0;
        do_reset();
        wr(8'h02, 32'd5); wr(8'h05, 32'd5); wr(8'h06, 32'd7); wr(8'h20, 32'h64);
        src_irq = 8'b0011_0010;
        ticks(6);
        chk("prio_top", 32'(irq_id), 32'd6);
        claim("prio_claim6", 32'd6);
        ticks(2);
        chk("prio_tie", 32'(irq_id), 32'd2);
        wr(8'h21, 32'd5);
        ticks(2);
        chk("prio_thresh", 32'(irq_out), 32'h0);
        rd("prio_pend_kept", 8'h22, 32'h24);

        // Edge deferral on source 4
        src_irq = '0;
        do_reset();
        wr(8'h04, 32'd3); wr(8'h20, 32'h10);
        src_irq[3] = 1'b1; ticks(4); src_irq[3] = 1'b0; ticks(4);
        rd("edge_pend", 8'h22, 32'h10);
        claim("edge_claim", 32'd4);
        for (int e = 0; e < 2; e++) begin
            src_irq[3] = 1'b1; ticks(4); src_irq[3] = 1'b0; ticks(4);
        end
        rd("edge_deferred", 8'h22, 32'h00);
        wr(8'h23, 32'd4);
        ticks(3);
        rd("edge_release", 8'h22, 32'h10);
        claim("edge_claim2", 32'd4);
        wr(8'h23, 32'd4);
        ticks(3);
        rd("edge_once", 8'h22, 32'h00);

        // Boundaries
        claim("empty_claim", 32'd0);
        rd("empty_pend", 8'h22, 32'h00);
        wr(8'h03, 32'd2); wr(8'h20, 32'h18);
        src_irq[2] = 1'b1; ticks(5);
        claim("bnd_claim3", 32'd3);
        wr(8'h23, 32'd9); ticks(3);
        rd("bnd_cmpl9", 8'h22, 32'h00);
        wr(8'h23, 32'd5); ticks(3);
        rd("bnd_cmpl_idle", 8'h22, 32'h00);
        wr(8'h23, 32'd3); ticks(3);
        rd("bnd_cmpl3", 8'h22, 32'h08);
        wr(8'h20, 32'hFFFF_FFFF);
        rd("bnd_enable", 8'h20, 32'h0000_01FE);
        wr(8'h01, 32'hFF);
        rd("bnd_prio_mask", 8'h01, 32'h7);
        wr(8'h30, 32'h55);
        rd("bnd_unmapped", 8'h30, 32'h0);

        // Claim collides with a new edge on source 1
        src_irq = '0;
        do_reset();
        wr(8'h01, 32'd1); wr(8'h20, 32'h02);
        src_irq[0] = 1'b1; ticks(4); src_irq[0] = 1'b0; ticks(4);
        chk("col_id", 32'(irq_id), 32'd1);
        src_irq[0] = 1'b1;
        ticks(SD);
        claim("col_claim", 32'd1);
        ticks(2);
        rd("col_pend0", 8'h22, 32'h00);
        wr(8'h23, 32'd1); ticks(2);
        rd("col_release", 8'h22, 32'h02);

        // Asynchronous reset mid-handshake
        wr(8'h03, 32'd2); wr(8'h20, 32'h0A);
        src_irq[2] = 1'b1; ticks(5);
        chk("ar_id3", 32'(irq_id), 32'd3);
        claim("ar_claim", 32'd3);
        ticks(2);
        chk("ar_id1", 32'(irq_id), 32'd1);
        #2; rst = 1'b1; #1;
        chk("ar_irq_out", 32'(irq_out), 32'h0);
        chk("ar_irq_id", 32'(irq_id), 32'h0);
        model_reset();
        rd("ar_pend", 8'h22, 32'h0);
        src_irq = '0;
        ticks(2);
        rst = 1'b0;
        tick();
        wr(8'h23, 32'd3); ticks(2);
        rd("ar_old_cmpl", 8'h22, 32'h0);

        // Random traffic against the model
        do_reset();
        for (int i = 1; i <= NUM; i++) wr(8'(i), $urandom);
        wr(8'h20, $urandom);
        wr(8'h21, 32'($urandom_range(0, 2)));
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) src_irq = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1: claim("rnd_claim", 32'(m_irq_id));
                2: wr(8'h23, 32'($urandom_range(0, 10)));
                3: begin a = addr_tab[$urandom_range(0, 11)]; wr(a, $urandom); end
                default: begin
                    a = addr_tab[$urandom_range(0, 11)];
                    rd("rnd_read", a, m_rdata(a));
                    tick();
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
